i2c_cmd_sequencer: RTL and testbench

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

---
 rtl/i2c_cmd_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: Wishbone master that drives an I2C master core through single-byte memory write/read transactions.
// Ports: wb_clk_i/arst_i (clock, async active-low reset); req_* request handshake (rw, 7-bit slave addr,
// memory addr, write data); rsp_* one-cycle completion pulse with read data, NACK and timeout flags;
// wb_* Wishbone master to the core. Optional macro I2C_CMD_SEQUENCER_TIMEOUT_EN bounds TIP polling.
module i2c_cmd_sequencer #(
  parameter logic [15:0] PRESCALE      = 16'h00FA,
  parameter int          TIMEOUT_POLLS = 1024
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_sadr,
  input  logic [7:0] req_madr,
  input  logic [7:0] req_wdat,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdat,
  output logic       rsp_nack,
  output logic       rsp_tout,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);
  typedef enum logic [2:0] {INIT, IDLE, BUS, GAP, POLL, ABORT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] step_q, step_d, len;
  logic cyc_q, cyc_d, we_q, we_d, apoll_q, apoll_d, rw_q, rw_d, nack_q, nack_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d, madr_q, madr_d, wdat_q, wdat_d, rdat_q, rdat_d, acc_dat;
  logic [6:0] sadr_q, sadr_d;
  logic ack, tip, timed, abt_tout, acc_txr, acc_wr, acc_poll, acc_rxr;
  assign ack = wb_ack_i & cyc_q;
  assign tip = wb_dat_i[1];
  // Flat step list: every third step polls SR; a read adds CR=0x68, its poll, and the RXR fetch.
  assign len = rw_q ? 4'd12 : 4'd9;
  assign acc_txr = step_q == 4'd0 || step_q == 4'd3 || step_q == 4'd6;
  assign acc_wr = step_q == 4'd2 || step_q == 4'd5 || step_q == 4'd8;
  assign acc_poll = acc_wr || step_q == 4'd10;
  assign acc_rxr = step_q == 4'd11;
  always_comb
    case (step_q)
      4'd0: acc_dat = {sadr_q, 1'b0};
      4'd1: acc_dat = 8'h90;
      4'd3: acc_dat = madr_q;
      4'd4: acc_dat = 8'h10;
      4'd6: acc_dat = rw_q ? {sadr_q, 1'b1} : wdat_q;
      4'd7: acc_dat = rw_q ? 8'h90 : 8'h50;
      4'd9: acc_dat = 8'h68;
      default: acc_dat = 8'h00;
    endcase
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    cyc_d = cyc_q;
    we_d = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    apoll_d = apoll_q;
    rw_d = rw_q;
    sadr_d = sadr_q;
    madr_d = madr_q;
    wdat_d = wdat_q;
    rdat_d = rdat_q;
    nack_d = nack_q;
    if (ack) begin
      cyc_d = 1'b0;
      we_d = 1'b0;
      adr_d = 3'd0;
      dat_d = 8'h00;
    end
    case (state_q)
      INIT:
        if (ack) step_d = step_q + 4'd1;
        else if (!cyc_q) begin
          if (step_q == 4'd3) begin
            step_d = 4'd0;
            state_d = IDLE;
          end else begin
            cyc_d = 1'b1;
            we_d = 1'b1;
            adr_d = step_q[2:0];
            dat_d = step_q == 4'd0 ? PRESCALE[7:0] : step_q == 4'd1 ? PRESCALE[15:8] : 8'h80;
          end
        end
      IDLE:
        if (req_valid) begin
          rw_d = req_rw;
          sadr_d = req_sadr;
          madr_d = req_madr;
          wdat_d = req_wdat;
          step_d = 4'd0;
          state_d = GAP;
        end
      GAP:
        if (step_q >= len) state_d = RESP;
        else begin
          cyc_d = 1'b1;
          we_d = !(acc_poll || acc_rxr);
          adr_d = acc_txr || acc_rxr ? 3'd3 : 3'd4;
          dat_d = acc_dat;
          state_d = acc_poll ? POLL : BUS;
        end
      BUS:
        if (ack) begin
          step_d = step_q + 4'd1;
          state_d = acc_rxr ? RESP : GAP;
          if (acc_rxr) begin
            rdat_d = wb_dat_i;
            nack_d = 1'b0;
          end
        end
      POLL:
        if (ack) begin
          if (tip) begin
            state_d = timed ? ABORT : GAP;
            apoll_d = 1'b0;
          end else if (acc_wr && wb_dat_i[7]) begin
            state_d = ABORT;
            apoll_d = 1'b0;
          end else begin
            step_d = step_q + 4'd1;
            state_d = step_q + 4'd1 == len ? RESP : GAP;
            if (step_q + 4'd1 == len) begin
              rdat_d = 8'h00;
              nack_d = 1'b0;
            end
          end
        end
      ABORT:
        if (ack) begin
          apoll_d = 1'b1;
          if (apoll_q && (!tip || timed)) begin
            state_d = RESP;
            rdat_d = 8'h00;
            nack_d = !abt_tout;
          end
        end else if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d = !apoll_q;
          adr_d = 3'd4;
          dat_d = apoll_q ? 8'h00 : 8'h40;
        end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge arst_i)
    if (!arst_i) begin
      state_q <= INIT;
      step_q <= 4'd0;
      cyc_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= 3'd0;
      dat_q <= 8'h00;
      apoll_q <= 1'b0;
      rw_q <= 1'b0;
      sadr_q <= 7'h00;
      madr_q <= 8'h00;
      wdat_q <= 8'h00;
      rdat_q <= 8'h00;
      nack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cyc_q <= cyc_d;
      we_q <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      apoll_q <= apoll_d;
      rw_q <= rw_d;
      sadr_q <= sadr_d;
      madr_q <= madr_d;
      wdat_q <= wdat_d;
      rdat_q <= rdat_d;
      nack_q <= nack_d;
    end
`ifdef I2C_CMD_SEQUENCER_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT_POLLS) + 1;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic abt_tout_q, abt_tout_d, tout_q, tout_d, resp_go;
  assign timed = poll_cnt_q >= PW'(TIMEOUT_POLLS - 1);
  assign abt_tout = abt_tout_q;
  assign rsp_tout = tout_q;
  assign resp_go = state_d == RESP && state_q != RESP;
  // The poll counter restarts whenever TIP clears or a timeout hands over to ABORT.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (ack && (state_q == POLL || (state_q == ABORT && apoll_q))) poll_cnt_d = tip && !timed ? poll_cnt_q + PW'(1) : '0;
    abt_tout_d = state_q == POLL && ack ? tip : abt_tout_q;
    tout_d = resp_go ? state_q == ABORT && (abt_tout_q || tip) : tout_q;
  end
  always_ff @(posedge wb_clk_i or negedge arst_i)
    if (!arst_i) begin
      poll_cnt_q <= '0;
      abt_tout_q <= 1'b0;
      tout_q <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      abt_tout_q <= abt_tout_d;
      tout_q <= tout_d;
    end
`else
  assign timed = 1'b0;
  assign abt_tout = 1'b0;
  assign rsp_tout = 1'b0;
`endif
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdat = rdat_q;
  assign rsp_nack = nack_q;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed bench with an I2C core/slave model and write/response scoreboards.
module tb_i2c_cmd_sequencer;
  logic wb_clk_i = 0, arst_i = 0, req_valid = 0, req_rw = 0, wb_ack_i = 0;
  logic [6:0] req_sadr = 0;
  logic [7:0] req_madr = 0, req_wdat = 0, wb_dat_i = 0;
  logic req_ready, rsp_valid, rsp_nack, rsp_tout, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [7:0] rsp_rdat, wb_dat_o;
  logic [2:0] wb_adr_o;
  typedef struct packed {logic [2:0] adr; logic [7:0] dat;} wr_t;
  typedef struct packed {logic chk_rdat; logic [7:0] rdat; logic nack; logic tout;} rsp_t;
  wr_t exp_wr[$];
  rsp_t exp_rsp[$];
  int checks = 0, errs = 0, rsp_seen = 0, tip_cnt = 0, byte_idx = 0, sr_reads = 0, sr_at_abort = 0;
  logic [7:0] mem [256];
  logic [7:0] txr = 0, rxr = 0, ptr = 0;
  logic rxack = 0, addressed = 0, tip_stuck = 0, stray = 0, rsp_prev = 0;

  i2c_cmd_sequencer #(.PRESCALE(16'h00FA), .TIMEOUT_POLLS(4)) dut (
    .wb_clk_i(wb_clk_i), .arst_i(arst_i), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_sadr(req_sadr), .req_madr(req_madr), .req_wdat(req_wdat),
    .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat), .rsp_nack(rsp_nack), .rsp_tout(rsp_tout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i));

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [2:0] adr, input logic [7:0] dat);
    exp_wr.push_back({adr, dat});
  endtask

  task automatic push_r(input logic c, input logic [7:0] rdat, input logic nack, input logic tout);
    exp_rsp.push_back({c, rdat, nack, tout});
  endtask

  // Behavioural I2C core: a CR write starts a byte that keeps TIP set for two SR reads.
  task automatic cr_write(input logic [7:0] cr);
    if (cr == 8'h40) sr_at_abort = sr_reads;
    sr_reads = 0;
    tip_cnt = 2;
    if (cr[4]) begin
      if (cr[7]) begin
        addressed = txr[7:1] == 7'h50;
        byte_idx = 0;
      end else if (addressed) begin
        if (byte_idx == 0) ptr = txr;
        else begin
          mem[ptr] = txr;
          ptr++;
        end
        byte_idx++;
      end
      rxack = !addressed;
    end
    if (cr[5]) begin
      rxr = mem[ptr];
      ptr++;
    end
  endtask

  always @(negedge wb_clk_i) begin
    wr_t e;
    rsp_t r;
    logic t;
    if (wb_ack_i) chk("stb_drop_after_ack", 32'(wb_stb_o), 0);
    if (arst_i && wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      wb_ack_i = 1'b1;
      if (wb_we_o) begin
        e = exp_wr.size() > 0 ? exp_wr.pop_front() : {3'h7, 8'hEE};
        chk("wb_write", 32'({wb_adr_o, wb_dat_o}), 32'(e));
        if (wb_adr_o == 3'd3) txr = wb_dat_o;
        if (wb_adr_o == 3'd4) cr_write(wb_dat_o);
      end else if (wb_adr_o == 3'd4) begin
        sr_reads++;
        t = tip_stuck || tip_cnt > 0;
        if (tip_cnt > 0) tip_cnt--;
        wb_dat_i = {rxack, 5'b0, t, 1'b0};
      end else wb_dat_i = rxr;
    end else wb_ack_i = stray;
    if (rsp_valid) begin
      chk("rsp_single_cycle", 32'(rsp_prev), 0);
      chk("rsp_expected", 32'(exp_rsp.size() > 0), 1);
      if (exp_rsp.size() > 0) begin
        r = exp_rsp.pop_front();
        chk("rsp_nack", 32'(rsp_nack), 32'(r.nack));
        chk("rsp_tout", 32'(rsp_tout), 32'(r.tout));
        if (r.chk_rdat) chk("rsp_rdat", 32'(rsp_rdat), 32'(r.rdat));
      end
      rsp_seen++;
    end
    rsp_prev = rsp_valid;
  end

  task automatic issue(input logic rw, input logic [6:0] sadr, input logic [7:0] madr, input logic [7:0] wdat);
    req_rw = rw;
    req_sadr = sadr;
    req_madr = madr;
    req_wdat = wdat;
    req_valid = 1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge wb_clk_i);
    chk("req_accepted", 32'(req_ready), 1);
    @(negedge wb_clk_i);
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 2000 && rsp_seen == n; i++) @(negedge wb_clk_i);
    chk("rsp_arrived", rsp_seen, n + 1);
    @(negedge wb_clk_i);
  endtask

  task automatic wait_init;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge wb_clk_i);
    chk("ready_after_init", 32'(req_ready), 1);
    chk("init_writes_drained", exp_wr.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge wb_clk_i);
    chk("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, req_ready, rsp_valid, rsp_nack, rsp_tout, rsp_rdat}, 0);
    push_w(3'd0, 8'hFA); push_w(3'd1, 8'h00); push_w(3'd2, 8'h80);
    #2 arst_i = 1;
    wait_init();
    // Write 0xA5 to slave 0x50 mem[1]; meanwhile present a request that must be ignored.
    push_w(3'd3, 8'hA0); push_w(3'd4, 8'h90); push_w(3'd3, 8'h01); push_w(3'd4, 8'h10);
    push_w(3'd3, 8'hA5); push_w(3'd4, 8'h50); push_r(0, 8'h00, 0, 0);
    n = rsp_seen;
    issue(0, 7'h50, 8'h01, 8'hA5);
    req_valid = 1; req_rw = 1; req_sadr = 7'h51;
    repeat (4) @(negedge wb_clk_i);
    req_valid = 0;
    wait_rsp(n);
    chk("mem1_written", 32'(mem[1]), 32'h A5);
    chk("ready_after_write", 32'(req_ready), 1);
    // Read slave 0x50 mem[1].
    push_w(3'd3, 8'hA0); push_w(3'd4, 8'h90); push_w(3'd3, 8'h01); push_w(3'd4, 8'h10);
    push_w(3'd3, 8'hA1); push_w(3'd4, 8'h90); push_w(3'd4, 8'h68); push_r(1, 8'hA5, 0, 0);
    n = rsp_seen;
    issue(1, 7'h50, 8'h01, 8'h00);
    wait_rsp(n);
    // Write then read back a second location.
    push_w(3'd3, 8'hA0); push_w(3'd4, 8'h90); push_w(3'd3, 8'h10); push_w(3'd4, 8'h10);
    push_w(3'd3, 8'h3C); push_w(3'd4, 8'h50); push_r(0, 8'h00, 0, 0);
    n = rsp_seen;
    issue(0, 7'h50, 8'h10, 8'h3C);
    wait_rsp(n);
    push_w(3'd3, 8'hA0); push_w(3'd4, 8'h90); push_w(3'd3, 8'h10); push_w(3'd4, 8'h10);
    push_w(3'd3, 8'hA1); push_w(3'd4, 8'h90); push_w(3'd4, 8'h68); push_r(1, 8'h3C, 0, 0);
    n = rsp_seen;
    issue(1, 7'h50, 8'h10, 8'h00);
    wait_rsp(n);
    // Absent slave: write and read both abort after the address byte.
    push_w(3'd3, 8'hA2); push_w(3'd4, 8'h90); push_w(3'd4, 8'h40); push_r(1, 8'h00, 1, 0);
    n = rsp_seen;
    issue(0, 7'h51, 8'h01, 8'h77);
    wait_rsp(n);
    chk("nack_no_extra_writes", exp_wr.size(), 0);
    push_w(3'd3, 8'hA2); push_w(3'd4, 8'h90); push_w(3'd4, 8'h40); push_r(1, 8'h00, 1, 0);
    n = rsp_seen;
    issue(1, 7'h51, 8'h05, 8'h00);
    wait_rsp(n);
    // Stray ack with no strobe must not disturb IDLE.
    n = rsp_seen;
    stray = 1;
    repeat (2) @(negedge wb_clk_i);
    stray = 0;
    @(negedge wb_clk_i);
    chk("stray_ack_ready", 32'(req_ready), 1);
    chk("stray_ack_no_rsp", rsp_seen, n);
    chk("stray_ack_no_cyc", 32'(wb_cyc_o), 0);
`ifdef I2C_CMD_SEQUENCER_TIMEOUT_EN
    tip_stuck = 1;
    push_w(3'd3, 8'hA0); push_w(3'd4, 8'h90); push_w(3'd4, 8'h40); push_r(1, 8'h00, 0, 1);
    n = rsp_seen;
    issue(0, 7'h50, 8'h02, 8'h11);
    wait_rsp(n);
    chk("sr_reads_before_abort", sr_at_abort, 4);
    tip_stuck = 0;
`endif
    // Reset during the second TXR write abandons the transaction and reruns INIT.
    push_w(3'd3, 8'hA0); push_w(3'd4, 8'h90); push_w(3'd3, 8'h01);
    n = rsp_seen;
    issue(0, 7'h50, 8'h01, 8'h77);
    for (int i = 0; i < 200 && !(wb_stb_o && wb_we_o && wb_adr_o == 3'd3 && wb_dat_o == 8'h01); i++) @(negedge wb_clk_i);
    chk("second_txr_seen", 32'({wb_stb_o, wb_adr_o, wb_dat_o}), 32'({1'b1, 3'd3, 8'h01}));
    #2 arst_i = 0;
    #1 chk("midreset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, req_ready, rsp_valid, rsp_nack, rsp_tout, rsp_rdat}, 0);
    exp_wr.delete();
    tip_cnt = 0;
    addressed = 0;
    push_w(3'd0, 8'hFA); push_w(3'd1, 8'h00); push_w(3'd2, 8'h80);
    repeat (2) @(negedge wb_clk_i);
    #2 arst_i = 1;
    wait_init();
    chk("midreset_no_rsp", rsp_seen, n);
    chk("midreset_mem_untouched", 32'(mem[1]), 32'h A5);
    chk("final_rsp_queue_empty", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
